// File: rtl/mux_cfg_loader.sv
// Serial loader for MUXN select fields: bits shift into a shadow register and commit atomically;
// sel_out updates on the edge after the last accept; cfg_ready is low outside SHIFT, and a restart aborts the frame.
module mux_cfg_loader #(
    parameter int NUM_MUX = 4,
    parameter int SWIDTH  = 6
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cfg_start,
    input  logic                        cfg_valid,
    input  logic                        cfg_bit,
    output logic                        cfg_ready,
    output logic                        cfg_busy,
    output logic                        cfg_done,
    output logic                        cfg_err,
    output logic [NUM_MUX*SWIDTH-1:0]   sel_out
);

    localparam int CW   = NUM_MUX * SWIDTH;
    localparam int CNTW = $clog2(CW + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(CW - 1);

    logic [1:0]      state;
    logic [CNTW-1:0] bit_cnt;
    logic [CW-1:0]   shadow;

    // Handshake outputs come straight from registered state, so they never glitch.
    assign cfg_ready = (state == ST_SHIFT);
    assign cfg_busy  = (state == ST_SHIFT) || (state == ST_COMMIT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            shadow   <= '0;
            sel_out  <= '0;
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cfg_start) begin
                        state   <= ST_SHIFT;
                        bit_cnt <= '0;
                        shadow  <= '0;
                    end
                end
                ST_SHIFT: begin
                    // A restart beats any bit offered in the same cycle, including the last one.
                    if (cfg_start) begin
                        bit_cnt <= '0;
                        shadow  <= '0;
                        cfg_err <= 1'b1;
                    end else if (cfg_valid) begin
                        shadow <= {cfg_bit, shadow[CW-1:1]};
                        if (bit_cnt == CNT_LAST) begin
                            state   <= ST_COMMIT;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                ST_COMMIT: begin
                    sel_out  <= shadow;
                    cfg_done <= 1'b1;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_cfg_loader.sv
// Directed + randomized bench for mux_cfg_loader against a queue-based frame model.
module tb_mux_cfg_loader;

    localparam int NUM_MUX = 4;
    localparam int SWIDTH  = 6;
    localparam int CW      = NUM_MUX * SWIDTH;

    logic          clk;
    logic          rst_n;
    logic          cfg_start;
    logic          cfg_valid;
    logic          cfg_bit;
    logic          cfg_ready;
    logic          cfg_busy;
    logic          cfg_done;
    logic          cfg_err;
    logic [CW-1:0] sel_out;

    mux_cfg_loader #(.NUM_MUX(NUM_MUX), .SWIDTH(SWIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_bit   (cfg_bit),
        .cfg_ready (cfg_ready),
        .cfg_busy  (cfg_busy),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .sel_out   (sel_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: a frame is a list of accepted bits; committing packs them LSB-first.
    bit            m_in_frame;
    bit            m_committing;
    bit            m_q[$];
    logic [CW-1:0] m_sel;
    logic          m_done;
    logic          m_err;

    int edge_n;
    int done_edge;
    int n_done;
    int n_err;
    int n_ready;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic s, input logic v, input logic b, input logic r);
        if (!r) begin
            m_in_frame   = 0;
            m_committing = 0;
            m_q.delete();
            m_sel  = '0;
            m_done = 0;
            m_err  = 0;
        end else begin
            m_done = 0;
            m_err  = 0;
            if (m_committing) begin
                for (int i = 0; i < CW; i++) m_sel[i] = m_q[i];
                m_q.delete();
                m_committing = 0;
                m_in_frame   = 0;
                m_done       = 1;
            end else if (m_in_frame) begin
                if (s) begin
                    m_q.delete();
                    m_err = 1;
                end else if (v) begin
                    m_q.push_back(b);
                    if (m_q.size() == CW) m_committing = 1;
                end
            end else if (s) begin
                m_in_frame = 1;
                m_q.delete();
            end
        end
    endtask

    task automatic cycle(input logic s, input logic v, input logic b, input logic r);
        cfg_start = s;
        cfg_valid = v;
        cfg_bit   = b;
        rst_n     = r;
        @(posedge clk);
        model_edge(s, v, b, r);
        edge_n++;
        #1;
        chk("sel_out",   sel_out,   m_sel);
        chk("cfg_ready", cfg_ready, m_in_frame && !m_committing);
        chk("cfg_busy",  cfg_busy,  m_in_frame);
        chk("cfg_done",  cfg_done,  m_done);
        chk("cfg_err",   cfg_err,   m_err);
        if (cfg_done === 1'b1) begin
            n_done++;
            if (done_edge < 0) done_edge = edge_n;
        end
        if (cfg_err === 1'b1) n_err++;
        if (cfg_ready === 1'b1) n_ready++;
    endtask

    task automatic clear_counts();
        edge_n    = 0;
        done_edge = -1;
        n_done    = 0;
        n_err     = 0;
        n_ready   = 0;
    endtask

    // gap_mode: 0 = valid every cycle, 1 = valid toggles starting low, 2 = random gaps
    task automatic send_bits(input logic [CW-1:0] val, input int nbits, input int gap_mode);
        for (int i = 0; i < nbits; i++) begin
            if (gap_mode == 1) begin
                cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
            end else if (gap_mode == 2) begin
                while ($urandom_range(0, 2) == 0)
                    cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
            end
            cycle(1'b0, 1'b1, val[i], 1'b1);
        end
    endtask

    task automatic load_frame(input logic [CW-1:0] val, input int gap_mode);
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        send_bits(val, CW, gap_mode);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    logic [36:0] mux_i;
    logic        mux_y;
    logic [CW-1:0] rnd;

    initial begin
        m_in_frame   = 0;
        m_committing = 0;
        m_sel        = '0;
        m_done       = 0;
        m_err        = 0;
        cfg_start    = 0;
        cfg_valid    = 0;
        cfg_bit      = 0;
        rst_n        = 0;
        clear_counts();

        // 1. Reset with random inputs, then idle with no start
        for (int i = 0; i < 2; i++)
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        chk("rst_sel_zero", sel_out, '0);
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        chk("idle_busy", cfg_busy, 1'b0);

        // 2. Continuous load; the start edge counts as edge 1, so the update lands on edge 26
        clear_counts();
        load_frame(24'hFC0905, 0);
        chk("full_value",    sel_out,   24'hFC0905);
        chk("full_upd_edge", done_edge, 26);
        chk("full_done_cnt", n_done,    1);
        chk("full_ready_cy", n_ready,   24);
        chk("mux1_field",    sel_out[SWIDTH +: SWIDTH], 6'd36);

        // 3. valid toggling every cycle
        clear_counts();
        load_frame(24'h123456, 1);
        chk("gap_value",    sel_out, 24'h123456);
        chk("gap_done_cnt", n_done,  1);
        chk("gap_ready_cy", n_ready, 48);

        // 4. Abort after 10 bits, restart bit offered with valid=1
        clear_counts();
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        send_bits(CW'($urandom), 10, 0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        chk("abort_err", cfg_err, 1'b1);
        chk("abort_sel", sel_out, 24'h123456);
        send_bits(24'hABCDEF, CW, 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        chk("abort_value",   sel_out, 24'hABCDEF);
        chk("abort_err_cnt", n_err,   1);

        // 5a. Start coincident with the final accept
        clear_counts();
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        send_bits(24'h555555, CW - 1, 0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        chk("coll_no_done", n_done,  0);
        chk("coll_err_cnt", n_err,   1);
        chk("coll_sel",     sel_out, 24'hABCDEF);
        // 5b. Start during the commit cycle is ignored
        clear_counts();
        send_bits(24'h0F0F0F, CW, 0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        chk("cstart_value",   sel_out,   24'h0F0F0F);
        chk("cstart_done",    n_done,    1);
        chk("cstart_err",     n_err,     0);
        chk("cstart_idle",    cfg_ready, 1'b0);

        // Randomized frames with random gaps and occasional restarts
        for (int f = 0; f < 4; f++) begin
            rnd = CW'($urandom);
            cycle(1'b1, 1'b0, 1'b0, 1'b1);
            if ($urandom_range(0, 1) == 1) begin
                send_bits(CW'($urandom), $urandom_range(0, CW - 1), 2);
                cycle(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
            end
            send_bits(rnd, CW, 2);
            cycle(1'b0, 1'b0, 1'b0, 1'b1);
            chk("rand_value", sel_out, rnd);
        end

        // 6. Reset mid-load
        load_frame(24'h00003F, 0);
        chk("pre_rst_value", sel_out, 24'h00003F);
        clear_counts();
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        send_bits(24'hFFFFFF, 12, 0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        chk("mid_rst_sel",   sel_out,   '0);
        chk("mid_rst_busy",  cfg_busy,  1'b0);
        chk("mid_rst_ready", cfg_ready, 1'b0);
        chk("mid_rst_done",  n_done,    0);
        chk("mid_rst_err",   n_err,     0);
        mux_i = 37'h1_0000F57CE;
        mux_y = (sel_out[SWIDTH-1:0] < 6'd37) ? mux_i[sel_out[SWIDTH-1:0]] : 1'bx;
        chk("muxn_out", mux_y, mux_i[0]);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
